// File: rtl/mdr_pkg.sv
// Shared MDR definitions: result-unload state encoding and word-select codes.
package mdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_RES = 2'd1,
        SHOW_REM = 2'd2
    } unload_state_e;

    localparam logic SEL_RESULT    = 1'b0;
    localparam logic SEL_REMAINDER = 1'b1;

endpackage

// File: rtl/result_unload_if.sv
// Bundle between the MDR core / host and the result unloader.
// master = core/host side, slave = unloader side.
interface result_unload_if #(parameter int WORD_LENGTH = 16);

    logic                   Done;
    logic [WORD_LENGTH-1:0] Result;
    logic [WORD_LENGTH-1:0] Remainder;
    logic                   Error;
    logic                   Next;
    logic [WORD_LENGTH-1:0] Data_out;
    logic                   Sel_out;
    logic                   Valid;
    logic                   Error_out;
    logic                   Ready;
    logic                   Overrun;

    modport master (
        output Done, Result, Remainder, Error, Next,
        input  Data_out, Sel_out, Valid, Error_out, Ready, Overrun
    );

    modport slave (
        input  Done, Result, Remainder, Error, Next,
        output Data_out, Sel_out, Valid, Error_out, Ready, Overrun
    );

endinterface

// File: rtl/Register.sv
// Generic enabled register with asynchronous active-high clear.
module Register #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q_o <= '0;
        else if (en_i) q_o <= d_i;
    end

endmodule

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse on the first sampled-high cycle of a level.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_q <= 1'b0;
        else       level_q <= level_i;
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/result_unload.sv
// Captures the MDR result bundle on Done and steps Result then Remainder out on Next edges.
// Optional sticky overrun flag is built only when UNLOAD_OVERRUN_EN is defined.
module result_unload
    import mdr_pkg::*;
#(
    parameter int WORD_LENGTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    result_unload_if.slave  bus
);

    unload_state_e          state_q, state_d;
    logic                   next_edge;
    logic                   cap_en;
    logic [WORD_LENGTH-1:0] rem_q;

    logic [WORD_LENGTH-1:0] data_out_q, data_out_d;
    logic                   sel_q, sel_d;
    logic                   valid_q, valid_d;
    logic                   err_out_q, err_out_d;
    logic                   ready_q, ready_d;

    rise_detect u_rise (
        .clk     (clk),
        .reset   (reset),
        .level_i (bus.Next),
        .rise_o  (next_edge)
    );

    assign cap_en = bus.Done & (state_q == IDLE);

    // Result and Error are held by the Data_out/Error_out registers themselves
    // for the whole sequence; only Remainder needs a separate holding register.
    Register #(.WIDTH(WORD_LENGTH)) u_cap_rem (
        .clk   (clk),
        .reset (reset),
        .en_i  (cap_en),
        .d_i   (bus.Remainder),
        .q_o   (rem_q)
    );

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        err_out_d  = err_out_q;
        ready_d    = ready_q;
        case (state_q)
            IDLE: begin
                // Done wins over a simultaneous Next edge; the edge is simply dropped.
                if (bus.Done) begin
                    state_d    = SHOW_RES;
                    data_out_d = bus.Result;
                    sel_d      = SEL_RESULT;
                    valid_d    = 1'b1;
                    err_out_d  = bus.Error;
                    ready_d    = 1'b0;
                end
            end
            SHOW_RES: begin
                if (next_edge) begin
                    state_d    = SHOW_REM;
                    data_out_d = rem_q;
                    sel_d      = SEL_REMAINDER;
                end
            end
            SHOW_REM: begin
                if (next_edge) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    sel_d      = SEL_RESULT;
                    valid_d    = 1'b0;
                    err_out_d  = 1'b0;
                    ready_d    = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                data_out_d = '0;
                sel_d      = SEL_RESULT;
                valid_d    = 1'b0;
                err_out_d  = 1'b0;
                ready_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            sel_q      <= SEL_RESULT;
            valid_q    <= 1'b0;
            err_out_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            err_out_q  <= err_out_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.Data_out  = data_out_q;
    assign bus.Sel_out   = sel_q;
    assign bus.Valid     = valid_q;
    assign bus.Error_out = err_out_q;
    assign bus.Ready     = ready_q;

`ifdef UNLOAD_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Clearing on the return to IDLE takes priority over a Done in that same cycle.
    always_comb begin
        ovr_d = ovr_q;
        if (state_q == SHOW_REM && next_edge) ovr_d = 1'b0;
        else if (bus.Done && state_q != IDLE) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovr_q <= 1'b0;
        else       ovr_q <= ovr_d;
    end

    assign bus.Overrun = ovr_q;
`else
    assign bus.Overrun = 1'b0;
`endif

endmodule

// File: tb/tb_result_unload.sv
// Self-checking bench for result_unload: directed scenarios then random traffic
// against a queue-based model of the words awaiting display.
module tb_result_unload;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    result_unload_if #(.WORD_LENGTH(W)) bus ();

    result_unload #(.WORD_LENGTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: words still to be shown, front is the one on display.
    logic [W-1:0] q[$];
    logic         m_err;
    logic         m_ovr;
    logic         prev_nxt;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic         v;
        logic [W-1:0] exp_data;
        logic         exp_ovr;
        v        = (q.size() != 0);
        exp_data = v ? q[0] : '0;
`ifdef UNLOAD_OVERRUN_EN
        exp_ovr  = m_ovr;
`else
        exp_ovr  = 1'b0;
`endif
        chk({tag, ".data"},  bus.Data_out,  exp_data);
        chk({tag, ".sel"},   bus.Sel_out,   q.size() == 1);
        chk({tag, ".valid"}, bus.Valid,     v);
        chk({tag, ".err"},   bus.Error_out, v ? m_err : 1'b0);
        chk({tag, ".ready"}, bus.Ready,     !v);
        chk({tag, ".ovr"},   bus.Overrun,   exp_ovr);
    endtask

    task automatic model_reset();
        q.delete();
        m_err    = 1'b0;
        m_ovr    = 1'b0;
        prev_nxt = 1'b0;
    endtask

    task automatic model_clock(input logic d, input logic [W-1:0] res, input logic [W-1:0] rem,
                               input logic err, input logic nxt);
        logic edge_seen;
        edge_seen = nxt && !prev_nxt;
        prev_nxt  = nxt;
        if (q.size() == 0) begin
            if (d) begin
                q.push_back(res);
                q.push_back(rem);
                m_err = err;
            end
        end else begin
            if (d) m_ovr = 1'b1;
            if (edge_seen) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_ovr = 1'b0;
                    m_err = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic d, input logic [W-1:0] res, input logic [W-1:0] rem,
                        input logic err, input logic nxt, input string tag);
        bus.Done      = d;
        bus.Result    = res;
        bus.Remainder = rem;
        bus.Error     = err;
        bus.Next      = nxt;
        @(posedge clk);
        model_clock(d, res, rem, err, nxt);
        #1;
        bus.Done = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic nxt_r;
        reset         = 1'b1;
        bus.Done      = 1'b0;
        bus.Result    = '0;
        bus.Remainder = '0;
        bus.Error     = 1'b0;
        bus.Next      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "idle");
        step(1'b1, 16'h0007, 16'h0003, 1'b0, 1'b0, "cap1");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "adv1");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "rel1");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "adv2");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "rel2");

        step(1'b1, 16'h0007, 16'h0003, 1'b0, 1'b0, "cap_hold");
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "held");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "held_rel");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "held_repress");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "held_rel2");

        step(1'b1, 16'h0007, 16'h0003, 1'b0, 1'b0, "ovr_cap");
        step(1'b1, 16'hBEEF, 16'h1234, 1'b1, 1'b0, "ovr_done");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "ovr_adv");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "ovr_rel");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "ovr_idle");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "ovr_rel2");

        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "err_cap");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "err_rem");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "err_rel");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "err_idle");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "err_rel2");

        step(1'b1, 16'h0055, 16'h0066, 1'b0, 1'b1, "done_edge");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "de_rel");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "de_adv");

        // Asynchronous reset between clock edges while in SHOW_REM.
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        bus.Next = 1'b0;
        reset    = 1'b0;
        step(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, "post_rst");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "post_rst_adv");

        nxt_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) nxt_r = ~nxt_r;
            step($urandom_range(0, 3) == 0, W'($urandom), W'($urandom),
                 $urandom_range(0, 1) == 1, nxt_r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_unload.md
Name: result_unload

Overview:
- Output-side counterpart of the MDR operand loader: captures the MDR result bundle when the core signals completion.
- Presents the bundle one word at a time on a shared output bus; the operator or host steps through the words with a Next push.
- Drives the Ready level back to the loader's state machine, so a new operation can only start once the previous results have been fully read out.

Parameters:
- WORD_LENGTH, 16, width of the Result, Remainder and Data_out words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Done  input  1  one-cycle pulse from the MDR core; Result, Remainder and Error are valid in that cycle.
- Result  input  WORD_LENGTH  quotient / product / root from the MDR core.
- Remainder  input  WORD_LENGTH  remainder from the MDR core (0 for multiply).
- Error  input  1  MDR error (divide by zero, negative root), valid with Done.
- Next  input  1  host/button level; each rising edge advances the display.
- Data_out  output  WORD_LENGTH  word currently presented.
- Sel_out  output  1  0 = Result shown, 1 = Remainder shown.
- Valid  output  1  high while Data_out holds a captured word.
- Error_out  output  1  captured Error, held while Valid.
- Ready  output  1  high in IDLE; connects to the loader's Ready input.
- Overrun  output  1  see Optional Feature.

Behaviour:
- All outputs are registered.
- Reset values: Data_out=0, Sel_out=0, Valid=0, Error_out=0, Ready=1, Overrun=0, state=IDLE, capture registers=0, Next_q=0.
- Next edge detection:
  - Next_q is a flop of Next.
  - next_edge = Next & ~Next_q.
  - A level held high gives exactly one advance.
- States and transitions:
  - IDLE: Ready=1, Valid=0, Data_out=0. On an edge with Done=1: capture Result, Remainder and Error into registers and go to SHOW_RES.
  - SHOW_RES: Data_out=captured Result, Sel_out=0, Valid=1, Ready=0, Error_out=captured Error. On next_edge, go to SHOW_REM.
  - SHOW_REM: Data_out=captured Remainder, Sel_out=1, Valid=1, Ready=0. On next_edge, go to IDLE.
- Latency:
  - Done sampled at edge k → SHOW_RES outputs visible from cycle k+1 (1 cycle).
  - Next first sampled high at edge k (Next_q=0) → new outputs visible from cycle k+1.
- Boundary conditions:
  - Done in SHOW_RES or SHOW_REM: ignored; captured data is not overwritten.
  - Done and next_edge together in IDLE: Done wins (capture); the edge is consumed and does not advance.
  - Next held high across the Done edge: no advance until Next goes low and then high again.
  - Error=1 at capture: the sequence is unchanged; both words are shown as delivered and Error_out=1 in both SHOW states.
  - Reset asserted mid-sequence: immediate return to reset values; captured data is cleared.
  - Return to IDLE: Ready rises in the same cycle that Valid falls.

Optional Feature:
- Macro: UNLOAD_OVERRUN_EN.
- Defined:
  - Overrun is a sticky flop, set by Done sampled while state ≠ IDLE.
  - Cleared on the transition SHOW_REM→IDLE, or by reset.
  - Visible one cycle after the offending Done.
- Not defined: Overrun is tied to 0 and no overrun logic is synthesised. The port remains present, so the top level is identical in both builds.

Decomposition:
- Shared package mdr_pkg:
  - typedef enum logic [1:0] unload_state_e {IDLE, SHOW_RES, SHOW_REM}.
  - Localparams SEL_RESULT=1'b0 and SEL_REMAINDER=1'b1.
- Sub-modules:
  - One natural sub-module: rise_detect (Next_q flop plus AND gate, with async reset).
  - Capture registers reuse the existing Register block (enable = Done & state==IDLE).

Test Plan:
- Reset, then Done with Result=16'h0007, Remainder=16'h0003, Error=0 → next cycle: Data_out=0007, Sel_out=0, Valid=1, Ready=0. First Next rise → Data_out=0003, Sel_out=1. Second Next rise → Valid=0, Ready=1, Data_out=0.
- Next held high for 10 cycles in SHOW_RES → exactly one advance to SHOW_REM. Release and re-press → IDLE.
- In SHOW_RES, Done with Result=16'hBEEF → Data_out stays 0007. With UNLOAD_OVERRUN_EN, Overrun=1 one cycle later and cleared on return to IDLE; without it, Overrun stays 0.
- Done with Error=1, Result=16'hFFFF, Remainder=0 → Error_out=1 in both SHOW states, 0 after return to IDLE.
- Done and a Next rising edge in the same IDLE cycle → state is SHOW_RES, not SHOW_REM. The following Next rise moves to SHOW_REM.
- Reset asserted asynchronously mid-SHOW_REM (between clock edges) → outputs return to reset values immediately, before the next edge. After release, a new Done with Result=16'h0010 shows 0010.
